// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the RNG request arbiter.
// State encoding, default widths and the bound-to-mask smear function.
package rng_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int MAX_TRIES_DEF = 8;
    localparam int IDX_W         = $clog2(NREQ_DEF);
    localparam int TRY_W         = $clog2(MAX_TRIES_DEF);

    // Smallest 2^k-1 covering b: copy every set bit into all lower bits.
    function automatic logic [31:0] smear_mask(input logic [31:0] b);
        logic [31:0] m;
        m = b;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

endpackage

// File: rtl/rng_request_arbiter_rr_picker.sv
// Round-robin picker: first set req bit after rr_ptr, wrapping.
// Ports: req, rr_ptr in; found, idx out. Purely combinational.
module rr_picker
    import rng_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand_idx;

    // Walk from the farthest slot back to rr_ptr+1 so the
    // nearest requester is the last (winning) assignment.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rng_request_arbiter.sv
// Shares one LFSR word stream between NREQ requesters, round-robin,
// returning a value in [0, bound] via mask-and-reject sampling.
// Ports: clk, rst (sync, active-high), rng_data, req, bound (packed,
// BITS per requester) in; gnt, rnd_val, rnd_valid, busy out (all
// registered). Optional macro RNG_NOREPEAT_EN rejects a repeat of
// the previous delivered value (except on fallback).
module rng_request_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BITS      = 11,
    parameter int MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BITS-1:0]      rng_data,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BITS-1:0] bound,
    output logic [NREQ-1:0]      gnt,
    output logic [BITS-1:0]      rnd_val,
    output logic                 rnd_valid,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx_l;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic [TW-1:0] tries;

    logic [BITS-1:0] bound_l;
    logic [BITS-1:0] mask_l;
    logic [BITS-1:0] bnd_sel;
    logic [BITS-1:0] cand;
    logic [BITS-1:0] fb_val;
    logic [BITS-1:0] out_val;
    logic            in_range;
    logic            accept;
    logic            last_try;
    logic            deliver;

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign bnd_sel  = bound[int'(pick_idx)*BITS +: BITS];
    assign cand     = rng_data & mask_l;
    assign in_range = (cand <= bound_l);
    assign last_try = (tries == TW'(MAX_TRIES - 1));

`ifdef RNG_NOREPEAT_EN
    logic [BITS-1:0] last_val;
    logic            last_vld;
    logic            repeat_hit;

    assign repeat_hit = last_vld && (cand == last_val)
                        && (bound_l != '0);
    assign accept     = in_range && !repeat_hit;
    // A rejected in-range repeat is delivered as-is on fallback;
    // out-of-range cand folds down (mask < 2*(bound+1)).
    assign fb_val     = in_range ? cand
                                 : cand - (bound_l + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_val <= '0;
            last_vld <= 1'b0;
        end else if (deliver) begin
            last_val <= out_val;
            last_vld <= 1'b1;
        end
    end
`else
    assign accept = in_range;
    // mask < 2*(bound+1), so the folded value is always <= bound.
    assign fb_val = cand - (bound_l + 1'b1);
`endif

    assign deliver = (state == SAMPLE) && (accept || last_try);
    assign out_val = accept ? cand : fb_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            rnd_valid <= 1'b0;
            rnd_val   <= '0;
            busy      <= 1'b0;
            tries     <= '0;
            rr_ptr    <= IW'(NREQ - 1);
            idx_l     <= '0;
            bound_l   <= '0;
            mask_l    <= '0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        idx_l   <= pick_idx;
                        bound_l <= bnd_sel;
                        mask_l  <= BITS'(smear_mask(32'(bnd_sel)));
                        rr_ptr  <= pick_idx;
                        tries   <= '0;
                        state   <= SAMPLE;
                        busy    <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (deliver) begin
                        rnd_val   <= out_val;
                        gnt       <= NREQ'(1) << idx_l;
                        rnd_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                DONE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // req is ignored here so a requester that drops
                    // req after gnt is not served a second time.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Scoreboard bench for rng_request_arbiter with directed vectors.
// Stimulus pushes expected deliveries; a negedge monitor checks them.
module tb_rng_request_arbiter;

    localparam int NREQ = 4;
    localparam int BITS = 11;

    logic                 clk;
    logic                 rst;
    logic [BITS-1:0]      rng_data;
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] bound;
    logic [NREQ-1:0]      gnt;
    logic [BITS-1:0]      rnd_val;
    logic                 rnd_valid;
    logic                 busy;

    typedef struct {
        logic [NREQ-1:0] g;
        logic [BITS-1:0] v;
        int              c;
        string           name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc;
    int   applied;
    int   miscmp;

    rng_request_arbiter #(
        .NREQ      (NREQ),
        .BITS      (BITS),
        .MAX_TRIES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rng_data  (rng_data),
        .req       (req),
        .bound     (bound),
        .gnt       (gnt),
        .rnd_val   (rnd_val),
        .rnd_valid (rnd_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every delivery must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rnd_valid || gnt != '0) begin
            if (sbq.size() == 0) begin
                applied++;
                miscmp++;
                $display("FAIL unexpected_delivery: gnt=%b val=%h",
                         gnt, rnd_val);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_gnt"}, int'(gnt), int'(e.g));
                chk({e.name, "_val"}, int'(rnd_val), int'(e.v));
                chk({e.name, "_cyc"}, cyc, e.c);
                chk({e.name, "_vld"}, int'(rnd_valid), 1);
            end
        end
    end

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        chk({nm, "_gnt"}, int'(gnt), 0);
        chk({nm, "_vld"}, int'(rnd_valid), 0);
        chk({nm, "_val"}, int'(rnd_val), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        rst = 1'b0;
    endtask

    // Single-requester transaction; d0/d1/d2 feed SAMPLE cycles 1/2/3+.
    task automatic txn(input string nm, input int r,
                       input logic [BITS-1:0] bnd,
                       input logic [BITS-1:0] d0,
                       input logic [BITS-1:0] d1,
                       input logic [BITS-1:0] d2,
                       input logic [BITS-1:0] ev,
                       input int lat, input bit early);
        int k;
        @(negedge clk);
        req = NREQ'(1 << r);
        bound[r*BITS +: BITS] = bnd;
        rng_data = d0;
        k = cyc;
        sbq.push_back('{g: NREQ'(1 << r), v: ev,
                        c: k + lat, name: nm});
        chk({nm, "_busy0"}, int'(busy), 0);
        for (int i = 1; i <= lat + 2; i++) begin
            @(negedge clk);
            rng_data = (i == 1) ? d0 : (i == 2) ? d1 : d2;
            if (early && i == 1) begin
                req = '0;
                bound[r*BITS +: BITS] = '0;
            end
            if (i == lat) req = '0;
            chk($sformatf("%s_busy%0d", nm, i), int'(busy),
                (i <= lat + 1) ? 1 : 0);
        end
    endtask

    initial begin
        int k;
        applied  = 0;
        miscmp   = 0;
        rst      = 1'b1;
        req      = '0;
        bound    = '0;
        rng_data = '0;

        do_reset("rst0");

        txn("t1_first", 0, 11'd5, 11'd3, 11'd3, 11'd3, 11'd3, 2, 0);
        txn("t2_rej2", 0, 11'd5, 11'd6, 11'd7, 11'd2, 11'd2, 4, 0);
        txn("t3_fallbk", 0, 11'd5, 11'd7, 11'd7, 11'd7, 11'd1, 9, 0);
        txn("t6_bnd0", 2, 11'd0, 11'h155, 11'h155, 11'h155,
            11'd0, 2, 0);
        txn("t6_bndmax", 3, 11'h7FF, 11'h5A3, 11'h5A3, 11'h5A3,
            11'h5A3, 2, 0);
        txn("bnd100", 1, 11'd100, 11'd200, 11'd200, 11'd200,
            11'd72, 2, 0);
        txn("drop", 1, 11'd9, 11'h0E, 11'h13, 11'h13, 11'd3, 3, 1);

        // Round robin with all four requesting, pointer fresh.
        do_reset("rst1");
        @(negedge clk);
        bound    = {NREQ{11'd5}};
        rng_data = 11'd3;
        req      = 4'b1111;
        k        = cyc;
        for (int i = 0; i < 5; i++)
            sbq.push_back('{g: NREQ'(1 << (i % NREQ)), v: 11'd3,
                            c: k + 2 + 4*i,
                            name: $sformatf("t4_rr%0d", i)});
        while (cyc < k + 18) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        // Reset during SAMPLE drops the transaction.
        bound[1*BITS +: BITS] = 11'd5;
        bound[2*BITS +: BITS] = 11'd5;
        rng_data = 11'd7;
        req      = 4'b0110;
        k        = cyc;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_gnt", int'(gnt), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_val", int'(rnd_val), 0);
        rst      = 1'b0;
        rng_data = 11'd3;
        k        = cyc;
        sbq.push_back('{g: 4'b0010, v: 11'd3, c: k + 2,
                        name: "t5_after1"});
        sbq.push_back('{g: 4'b0100, v: 11'd3, c: k + 6,
                        name: "t5_after2"});
        while (cyc < k + 6) @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);

        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscmp);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
